// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage with PC, loadable imem,
// next-PC resolution and load/run/halt control.
//
// Ports:
//   clk, rst            clock, sync active-high reset
//   load_en/addr/data   imem write port (IDLE/HALT only)
//   start               run from RESET_PC (IDLE/HALT only)
//   stall               hold PC and counter
//   Jump, Branch, Zero  decoder/ALU next-PC controls
//   Instruction         current word (0 outside RUN/range)
//   PC, PCPlus4         program counter and PC + 4
//   running, halted     run-control state
//   fault               sticky out-of-range fetch flag
//   instr_count         retired instructions since start
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
  localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          stall,
  input  logic          Jump,
  input  logic          Branch,
  input  logic          Zero,
  output logic [31:0]   Instruction,
  output logic [31:0]   PC,
  output logic [31:0]   PCPlus4,
  output logic          running,
  output logic          halted,
  output logic          fault,
  output logic [31:0]   instr_count
);

  typedef enum logic [1:0] {
    Idle,
    Run,
    Halt
  } state_t;

  state_t      stateQ;
  state_t      stateD;
  logic [31:0] pcD;
  logic [31:0] cntD;
  logic        faultD;
  logic        retire;

  logic [31:0] imem [IMEM_DEPTH];

  logic        inRange;
  logic        ctlOpen;
  logic [31:0] fetched;
  logic [31:0] jumpPc;
  logic [31:0] brOff;
  logic [31:0] branchPc;

  // PC < 4*IMEM_DEPTH iff no bits above the byte index are set
  assign inRange  = PC[31:AW+2] == '0;
  assign fetched  = imem[PC[AW+1:2]];
  assign ctlOpen  = stateQ != Run;

  assign Instruction =
    (stateQ == Run && inRange) ? fetched : '0;

  assign PCPlus4  = PC + 32'd4;
  assign jumpPc   = {PCPlus4[31:28],
                     Instruction[25:0], 2'b00};
  assign brOff    = {{14{Instruction[15]}},
                     Instruction[15:0], 2'b00};
  assign branchPc = PCPlus4 + brOff;

  assign running  = stateQ == Run;
  assign halted   = stateQ == Halt;

  // Memory is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (!rst && load_en && ctlOpen) begin
      imem[load_addr] <= load_data;
    end
  end

  always_comb begin
    stateD = stateQ;
    pcD    = PC;
    cntD   = instr_count;
    faultD = fault;
    retire = 1'b0;
    unique case (stateQ)
      Idle, Halt: begin
        if (start) begin
          stateD = Run;
          pcD    = RESET_PC;
          cntD   = '0;
          faultD = 1'b0;
        end
      end
      Run: begin
        // range fault outranks stall
        if (!inRange) begin
          stateD = Halt;
          faultD = 1'b1;
        end else if (stall) begin
          stateD = Run;
        end else if (Instruction == HALT_WORD) begin
          stateD = Halt;
        end else begin
          retire = 1'b1;
          if (Jump) begin
            pcD = jumpPc;
          end else if (Branch && Zero) begin
            pcD = branchPc;
          end else begin
            pcD = PCPlus4;
          end
        end
      end
      default: stateD = Idle;
    endcase
    if (retire) begin
      cntD = instr_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= Idle;
      PC          <= RESET_PC;
      instr_count <= '0;
      fault       <= 1'b0;
    end else begin
      stateQ      <= stateD;
      PC          <= pcD;
      instr_count <= cntD;
      fault       <= faultD;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus random stimulus
// against a behavioural fetch/run model.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HW    = 32'hFC00_0000;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] BEQ2  = 32'h1000_0002;
  localparam logic [31:0] J5    = 32'h0800_0005;
  localparam logic [31:0] J6    = 32'h0800_0006;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [1:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        running;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .start(start),
    .stall(stall),
    .Jump(Jump),
    .Branch(Branch),
    .Zero(Zero),
    .Instruction(Instruction),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .running(running),
    .halted(halted),
    .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chkEn = 1'b0;

  bit          mRun;
  bit          mHalt;
  bit          mFault;
  logic [31:0] mPc;
  logic [31:0] mCnt;
  logic [31:0] mMem [DEPTH];

  function automatic logic [31:0] mInstr();
    if (mRun && mPc < 4 * DEPTH)
      return mMem[int'(mPc >> 2)];
    return 32'h0;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(posedge clk) begin : model
    logic [31:0] ins;
    int          off;
    if (rst) begin
      mRun = 0; mHalt = 0; mFault = 0;
      mPc = 32'h0; mCnt = 32'h0;
    end else if (!mRun) begin
      if (load_en) mMem[load_addr] = load_data;
      if (start) begin
        mRun = 1; mHalt = 0; mFault = 0;
        mPc = 32'h0; mCnt = 32'h0;
      end
    end else begin
      ins = mInstr();
      if (mPc >= 4 * DEPTH) begin
        mRun = 0; mHalt = 1; mFault = 1;
      end else if (stall) begin
        mRun = 1;
      end else if (ins == HW) begin
        mRun = 0; mHalt = 1;
      end else begin
        mCnt = mCnt + 1;
        if (Jump) begin
          mPc = ((mPc + 4) & 32'hF000_0000)
              | ((ins & 32'h03FF_FFFF) << 2);
        end else if (Branch && Zero) begin
          off = $signed(ins[15:0]);
          mPc = mPc + 4 + 32'(off * 4);
        end else begin
          mPc = mPc + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("Instruction", Instruction, mInstr());
      chk("PC", PC, mPc);
      chk("PCPlus4", PCPlus4, mPc + 32'd4);
      chk("running", 32'(running), 32'(mRun));
      chk("halted", 32'(halted), 32'(mHalt));
      chk("fault", 32'(fault), 32'(mFault));
      chk("instr_count", instr_count, mCnt);
    end
  end

  task automatic load(int a, logic [31:0] d);
    load_en = 1; load_addr = 2'(a); load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = NOP; prog[1] = NOP;
    prog[2] = NOP; prog[3] = HW;

    tick();
    chkEn = 1;
    chk("lit_rst_pc", PC, 32'h0);
    chk("lit_rst_pc4", PCPlus4, 32'h4);
    chk("lit_rst_ins", Instruction, 32'h0);
    chk("lit_rst_cnt", instr_count, 32'h0);
    chk("lit_rst_flags",
        {29'h0, running, halted, fault}, 32'h0);
    rst = 0;

    for (int i = 0; i < 4; i++) load(i, prog[i]);
    go();
    chk("lit_seq_pc0", PC, 32'h0);
    chk("lit_seq_run", 32'(running), 32'h1);
    tick(); chk("lit_seq_pc4", PC, 32'h4);
    tick(); chk("lit_seq_pc8", PC, 32'h8);
    tick(); chk("lit_seq_pc12", PC, 32'hC);
    chk("lit_seq_ins", Instruction, HW);
    tick();
    chk("lit_seq_halt", 32'(halted), 32'h1);
    chk("lit_seq_hpc", PC, 32'hC);
    chk("lit_seq_cnt", instr_count, 32'h3);

    load(0, BEQ2);
    Branch = 1; Zero = 1;
    go();
    tick();
    chk("lit_beq_taken", PC, 32'hC);
    Branch = 0; Zero = 0;
    tick();
    chk("lit_beq_cnt", instr_count, 32'h1);

    Branch = 1;
    go();
    tick();
    chk("lit_beq_not", PC, 32'h4);
    Branch = 0;
    tick(); tick(); tick();
    chk("lit_bnt_halt", 32'(halted), 32'h1);
    chk("lit_bnt_cnt", instr_count, 32'h3);

    load(0, J5);
    Jump = 1;
    go();
    tick();
    chk("lit_j5_pc", PC, 32'h14);
    Jump = 0;
    tick();
    chk("lit_j5_fault", 32'(fault), 32'h1);

    load(0, J6);
    Jump = 1;
    go();
    tick();
    chk("lit_j6_pc", PC, 32'h18);
    Jump = 0;
    tick();
    chk("lit_flt_halt", 32'(halted), 32'h1);
    chk("lit_flt_fault", 32'(fault), 32'h1);
    chk("lit_flt_ins", Instruction, 32'h0);
    go();
    chk("lit_flt_clr", 32'(fault), 32'h0);
    chk("lit_flt_pc", PC, 32'h0);
    tick(); tick(); tick(); tick();

    load(0, NOP);
    go();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_stall_pc", PC, 32'h8);
      chk("lit_stall_cnt", instr_count, 32'h2);
    end
    stall = 0;
    tick();
    chk("lit_unstall_pc", PC, 32'hC);
    tick();

    go();
    tick(); tick();
    chk("lit_mid_pc8", PC, 32'h8);
    rst = 1;
    tick();
    rst = 0;
    chk("lit_mid_pc", PC, 32'h0);
    chk("lit_mid_run", 32'(running), 32'h0);
    chk("lit_mid_cnt", instr_count, 32'h0);
    chk("lit_mid_ins", Instruction, 32'h0);
    go();
    tick(); tick(); tick(); tick();
    chk("lit_rerun_cnt", instr_count, 32'h3);
    chk("lit_rerun_pc", PC, 32'hC);

    go();
    load(1, HW);
    chk("lit_runld_ins", Instruction, 32'h0);
    tick(); tick(); tick();
    chk("lit_runld_cnt", instr_count, 32'h3);

    load_en = 1; load_addr = 2'd0; load_data = HW;
    start = 1;
    tick();
    load_en = 0; start = 0;
    chk("lit_ls_ins", Instruction, HW);
    tick();
    chk("lit_ls_halt", 32'(halted), 32'h1);
    chk("lit_ls_cnt", instr_count, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 99) == 0;
      load_en = $urandom_range(0, 2) == 0;
      load_addr = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: load_data = NOP;
        1: load_data = HW;
        2: load_data = {6'h04, 10'h0,
             16'($urandom_range(0, 8)) - 16'd4};
        3: load_data = {6'h02,
             26'($urandom_range(0, 5))};
        default: load_data = $urandom;
      endcase
      start = $urandom_range(0, 5) == 0;
      stall = $urandom_range(0, 3) == 0;
      Jump = $urandom_range(0, 3) == 0;
      Branch = $urandom_range(0, 1) == 1;
      Zero = $urandom_range(0, 1) == 1;
      tick();
    end

    rst = 0; load_en = 0; start = 0;
    stall = 0; Jump = 0; Branch = 0; Zero = 0;
    tick();
    chkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the single-cycle MIPS datapath. It holds the program counter and a loadable word-addressed instruction memory, and presents the current instruction to the opcode decoder (Instruction[31:26] is the decoder's OpCode). It closes the next-PC loop from the decoder's Jump and Branch outputs and the ALU Zero flag. A small run-control state machine handles program load, run, halt and out-of-range PC fault, and keeps a retired-instruction counter.

## Interface
Parameters:
- IMEM_DEPTH, 256, instruction memory size in 32-bit words; power of two, at least 4.
- RESET_PC, 32'h0000_0000, byte address of the first instruction; word-aligned.
- HALT_WORD, 32'hFC00_0000, instruction encoding (opcode 111111) that stops execution.

Ports (AW = log2(IMEM_DEPTH)):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write load_data into imem[load_addr]; honoured only in IDLE or HALT.
- load_addr  in  AW  word address for the load.
- load_data  in  32  instruction word to load.
- start  in  1  begin execution from RESET_PC; honoured only in IDLE or HALT.
- stall  in  1  hold PC and counter for this cycle.
- Jump  in  1  from the decoder.
- Branch  in  1  from the decoder.
- Zero  in  1  from the ALU.
- Instruction  out  32  current instruction (combinational).
- PC  out  32  current program counter (registered).
- PCPlus4  out  32  PC + 4 (combinational, modulo 2^32).
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- fault  out  1  sticky; set when a fetch addresses beyond the memory.
- instr_count  out  32  instructions retired since the last start.

## Operation
States: IDLE (after reset), RUN, HALT.

IDLE:
- Instruction = 0 (NOP).
- load_en writes memory.
- start moves to RUN with PC <= RESET_PC, instr_count <= 0 and fault <= 0.

RUN fetch:
- inrange = PC < 4*IMEM_DEPTH.
- Instruction = inrange ? imem[PC[AW+1:2]] : 0.
- Memory read is asynchronous. The decoder, ALU and Zero resolve in the same cycle.

RUN next-PC. Priority, top down, evaluated at each rising edge:
1. !inrange: go to HALT, fault <= 1, PC holds. Evaluated before stall.
2. stall: PC, state and instr_count hold.
3. Instruction == HALT_WORD: go to HALT, PC holds, instr_count unchanged.
4. Jump: PC <= {PCPlus4[31:28], Instruction[25:0], 2'b00}.
5. Branch & Zero: PC <= PCPlus4 + ({{14{Instruction[15]}}, Instruction[15:0], 2'b00}), modulo 2^32.
6. Otherwise: PC <= PCPlus4.

RUN counter and load:
- Cases 4–6 retire one instruction: instr_count += 1, wrapping 2^32−1 to 0.
- load_en and start are ignored in RUN.

HALT:
- Instruction = 0, and PC holds its last value.
- load_en is honoured.
- start behaves as in IDLE and clears fault.

Simultaneous load_en and start (IDLE or HALT): both take effect. The loaded word is visible on the first RUN cycle.

Reset:
- rst has priority over every other input, including mid-RUN.
- Reset values: state IDLE, PC = RESET_PC, instr_count = 0, fault = 0, running = 0, halted = 0, Instruction = 0, PCPlus4 = RESET_PC + 4.
- Memory contents are not cleared by rst.

## Timing
- PC update latency is 1 cycle. A jump or branch resolved in cycle n fetches its target in cycle n+1. There are no delay slots.
- Instruction, PCPlus4 and the next-PC are combinational from PC and memory. The decode/ALU path must close within one clk period.
- A start asserted at edge k gives running = 1 and PC = RESET_PC after edge k. The first instruction is presented in that cycle.
- The memory write occurs at the edge where load_en is sampled. Read-after-write data is valid in the following cycle.
- halted and fault are registered and assert in the cycle after the triggering edge.

## Test plan
- Sequential run: load words 0–3 with 3 NOPs then HALT_WORD, pulse start → PC steps 0, 4, 8, 12. halted = 1 with PC = 12 and instr_count = 3.
- Branch and jump: word 0 = beq with imm = 2 (Branch = 1, Zero = 1) → next PC = 12. Same with Zero = 0 → next PC = 4. Word 0 = j with target 5 → next PC = 20.
- Stall: assert stall for 3 cycles in RUN at PC = 8 → PC stays 8 and instr_count is unchanged. Then PC advances to 12 on release.
- Fault: IMEM_DEPTH = 4 with a jump to word 6 → PC = 24, next cycle halted = 1, fault = 1, Instruction = 0. A following start clears fault, and PC = 0.
- Reset mid-run: assert rst at PC = 8 → state IDLE, PC = 0, instr_count = 0, Instruction = 0. Memory still holds the program, and start re-runs it identically.
- Load/start interaction: load_en during RUN → memory unchanged. load_en and start together in IDLE writing word 0 = HALT_WORD → halted after 1 cycle with instr_count = 0.
